// File: rtl/ntps_phy_pkg.sv
// Shared definitions for the SFP/PHY port controller: port FSM state
// encoding, PMD type encodings and xphy_status bit positions.
package ntps_phy_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_NO_MODULE = 3'd1,
        ST_WAIT_SIG  = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_UP        = 3'd4,
        ST_FAULT     = 3'd5
    } port_state_e;

    localparam logic [2:0] PMD_ER = 3'b101;
    localparam logic [2:0] PMD_LR = 3'b110;
    localparam logic [2:0] PMD_SR = 3'b111;

    localparam int STAT_W              = 5;
    localparam int STAT_QPLLLOCK       = 0;
    localparam int STAT_MODULE_PRESENT = 1;
    localparam int STAT_SIGNAL_DETECT  = 2;
    localparam int STAT_TX_FAULT       = 3;
    localparam int STAT_BLOCK_LOCK     = 4;

    // Map the two PMD-select config bits onto the PHY core's PMD type code.
    function automatic logic [2:0] pmd_decode(input logic [1:0] sel);
        if (sel[1])
            return PMD_SR;
        else if (sel[0])
            return PMD_LR;
        else
            return PMD_ER;
    endfunction

endpackage

// File: rtl/ntps_phy_port_fsm.sv
// One SFP port: pin synchroniser, signal-detect debounce, link FSM and
// link-flap counter. Flap counter present only with NTPS_PHY_FLAP_CNT_EN.
module ntps_phy_port_fsm
    import ntps_phy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1024,
    parameter int FAULT_HOLD_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              detect_n_i,
    input  logic              lost_i,
    input  logic              fault_i,
    input  logic              qplllock_i,
    input  logic              block_lock_i,
    input  logic              flap_clr_i,
    output logic              tx_disable_o,
    output logic              signal_detect_o,
    output logic              link_up_o,
    output logic [15:0]       flap_cnt_o,
    output logic [STAT_W-1:0] status_o
);

    localparam int              DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int              HOLD_W    = $clog2(FAULT_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FAULT_HOLD_CYCLES - 1);

    // Bit order {fault, lost, detect_n}; reset value is the "no usable module" view.
    logic [2:0]        meta_q, sync_q;
    logic              detect_n_s, lost_s, fault_s;
    logic [DB_W-1:0]   db_cnt_q;
    logic              sig_det_q;
    logic [HOLD_W-1:0] hold_q;
    port_state_e       state_q, state_d;
    logic              tx_disable_q, link_up_q;

    // Two-flop synchroniser for the raw SFP pins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 3'b111;
            sync_q <= 3'b111;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            meta_q <= {fault_i, lost_i, detect_n_i};
            sync_q <= meta_q;
        end
    end

    assign detect_n_s = sync_q[0];
    assign lost_s     = sync_q[1];
    assign fault_s    = sync_q[2];

    // Debounce: count consecutive good cycles, drop immediately on loss.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            db_cnt_q  <= '0;
            sig_det_q <= 1'b0;
        end else if (lost_s) begin
            db_cnt_q  <= '0;
            sig_det_q <= 1'b0;
        end else if (!sig_det_q) begin
            if (db_cnt_q == DB_LAST)
                sig_det_q <= 1'b1;
            else
                db_cnt_q <= db_cnt_q + DB_W'(1);
        end
    end

    // Next-state logic; the first three checks override the normal flow.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (!enable_i)
            state_d = ST_OFF;
        else if (detect_n_s)
            state_d = ST_NO_MODULE;
        else if (fault_s && state_q != ST_FAULT)
            state_d = ST_FAULT;
        else begin
            case (state_q)
                ST_OFF:       state_d = ST_NO_MODULE;
                ST_NO_MODULE: state_d = ST_WAIT_SIG;
                ST_WAIT_SIG:  if (sig_det_q) state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: if (qplllock_i && block_lock_i) state_d = ST_UP;
                ST_UP:        if (!sig_det_q || !qplllock_i || !block_lock_i) state_d = ST_WAIT_SIG;
                ST_FAULT:     if (hold_q == '0 && !fault_s) state_d = ST_WAIT_SIG;
                default:      state_d = ST_OFF;
            endcase
        end
    end

    // State register plus registered decodes of the current state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_OFF;
            tx_disable_q <= 1'b1;
            link_up_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_disable_q <= (state_q == ST_OFF) || (state_q == ST_NO_MODULE) ||
                            (state_q == ST_FAULT);
            link_up_q    <= (state_q == ST_UP);
        end
    end

    // Fault hold timer: preloaded while outside FAULT, so it is full on entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            hold_q <= '0;
        else if (state_q != ST_FAULT || hold_q == '0)
            hold_q <= HOLD_LAST;
        else
            hold_q <= hold_q - HOLD_W'(1);
    end

`ifdef NTPS_PHY_FLAP_CNT_EN
    logic [15:0] flap_q;
    logic        leave_up;

    assign leave_up = (state_q == ST_UP) && (state_d != ST_UP);

    // Saturating flap counter; a clear coinciding with a flap leaves one flap counted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            flap_q <= '0;
        else if (leave_up && flap_clr_i)
            flap_q <= 16'd1;
        else if (flap_clr_i)
            flap_q <= '0;
        else if (leave_up && flap_q != 16'hFFFF)
            flap_q <= flap_q + 16'd1;
    end

    assign flap_cnt_o = flap_q;
`else
    logic flap_clr_unused;

    assign flap_clr_unused = flap_clr_i;
    assign flap_cnt_o      = '0;
`endif

    assign tx_disable_o    = tx_disable_q;
    assign signal_detect_o = sig_det_q;
    assign link_up_o       = link_up_q;

    assign status_o[STAT_QPLLLOCK]       = qplllock_i;
    assign status_o[STAT_MODULE_PRESENT] = ~detect_n_s;
    assign status_o[STAT_SIGNAL_DETECT]  = sig_det_q;
    assign status_o[STAT_TX_FAULT]       = fault_s;
    assign status_o[STAT_BLOCK_LOCK]     = block_lock_i;

endmodule

// File: rtl/ntps_phy_ctrl.sv
// Multi-port 10G SFP PHY controller: one independent port FSM per SFP
// port, sharing only the QPLL lock. Flap counters enabled by
// NTPS_PHY_FLAP_CNT_EN (tied to zero when undefined).
module ntps_phy_ctrl
    import ntps_phy_pkg::*;
#(
    parameter int NUM_PORTS         = 4,
    parameter int DEBOUNCE_CYCLES   = 1024,
    parameter int FAULT_HOLD_CYCLES = 16
) (
    input  logic                   clk156,
    input  logic                   areset_clk156,
    input  logic [3*NUM_PORTS-1:0] xphy_config,
    input  logic [NUM_PORTS-1:0]   sfp_module_detect_n,
    input  logic [NUM_PORTS-1:0]   sfp_signal_lost,
    input  logic [NUM_PORTS-1:0]   sfp_tx_fault,
    input  logic                   qplllock,
    input  logic [8*NUM_PORTS-1:0] core_status,
    input  logic [NUM_PORTS-1:0]   flap_clr,
    output logic [NUM_PORTS-1:0]   sfp_tx_disable,
    output logic [NUM_PORTS-1:0]   signal_detect,
    output logic [3*NUM_PORTS-1:0] pma_pmd_type,
    output logic [5*NUM_PORTS-1:0] xphy_status,
    output logic [NUM_PORTS-1:0]   link_up,
    output logic [16*NUM_PORTS-1:0] flap_cnt
);

    // Only bit 0 (PCS block lock) of each core status byte is consumed.
    logic [8*NUM_PORTS-1:0] core_status_unused;

    assign core_status_unused = core_status;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        ntps_phy_port_fsm #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .FAULT_HOLD_CYCLES (FAULT_HOLD_CYCLES)
        ) u_port (
            .clk_i           (clk156),
            .rst_i           (areset_clk156),
            .enable_i        (xphy_config[3*p]),
            .detect_n_i      (sfp_module_detect_n[p]),
            .lost_i          (sfp_signal_lost[p]),
            .fault_i         (sfp_tx_fault[p]),
            .qplllock_i      (qplllock),
            .block_lock_i    (core_status[8*p]),
            .flap_clr_i      (flap_clr[p]),
            .tx_disable_o    (sfp_tx_disable[p]),
            .signal_detect_o (signal_detect[p]),
            .link_up_o       (link_up[p]),
            .flap_cnt_o      (flap_cnt[16*p +: 16]),
            .status_o        (xphy_status[STAT_W*p +: STAT_W])
        );

        assign pma_pmd_type[3*p +: 3] = pmd_decode(xphy_config[3*p+1 +: 2]);
    end

endmodule

// File: tb/tb_ntps_phy_ctrl.sv
// Self-checking bench for ntps_phy_ctrl: bring-up timing, signal glitch,
// tx_fault hold/retry, PMD decode, disable, flap counter and async reset.
module tb_ntps_phy_ctrl;

    localparam int NP = 2;
    localparam int DB = 8;
    localparam int FH = 16;

`ifdef NTPS_PHY_FLAP_CNT_EN
    localparam bit FLAP_EN = 1'b1;
`else
    localparam bit FLAP_EN = 1'b0;
`endif

    logic               clk156 = 1'b0;
    logic               areset_clk156;
    logic [3*NP-1:0]    xphy_config;
    logic [NP-1:0]      sfp_module_detect_n, sfp_signal_lost, sfp_tx_fault, flap_clr;
    logic               qplllock;
    logic [8*NP-1:0]    core_status;
    logic [NP-1:0]      sfp_tx_disable, signal_detect, link_up;
    logic [3*NP-1:0]    pma_pmd_type;
    logic [5*NP-1:0]    xphy_status;
    logic [16*NP-1:0]   flap_cnt;

    ntps_phy_ctrl #(
        .NUM_PORTS         (NP),
        .DEBOUNCE_CYCLES   (DB),
        .FAULT_HOLD_CYCLES (FH)
    ) dut (
        .clk156              (clk156),
        .areset_clk156       (areset_clk156),
        .xphy_config         (xphy_config),
        .sfp_module_detect_n (sfp_module_detect_n),
        .sfp_signal_lost     (sfp_signal_lost),
        .sfp_tx_fault        (sfp_tx_fault),
        .qplllock            (qplllock),
        .core_status         (core_status),
        .flap_clr            (flap_clr),
        .sfp_tx_disable      (sfp_tx_disable),
        .signal_detect       (signal_detect),
        .pma_pmd_type        (pma_pmd_type),
        .xphy_status         (xphy_status),
        .link_up             (link_up),
        .flap_cnt            (flap_cnt)
    );

    always #5 clk156 = ~clk156;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [63:0] act);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow: got 0x%0h with no expectation queued", act);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, act, e.val);
        end
    endtask

    function automatic logic [15:0] flap_exp(input int n);
        return FLAP_EN ? 16'(n) : 16'd0;
    endfunction

    // Cycles from the reset-release negedge until tx_disable falls,
    // signal_detect rises and link_up rises (-1 when not seen).
    task automatic measure_bringup(input int port, input int max,
                                   output int t_txd, output int t_sd, output int t_link);
        t_txd = -1; t_sd = -1; t_link = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk156); #1;
            if (t_txd  < 0 && !sfp_tx_disable[port]) t_txd  = i;
            if (t_sd   < 0 && signal_detect[port])   t_sd   = i;
            if (t_link < 0 && link_up[port])         t_link = i;
        end
    endtask

    task automatic wait_link(input int port, input int max, output int t);
        t = -1;
        for (int i = 1; i <= max && t < 0; i++) begin
            @(posedge clk156); #1;
            if (link_up[port]) t = i;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_txd, t_sd, t_link, t_fall_sd, t_fall_link, t_back;
        int hi_cnt, first_hi;
        logic fault_bit;

        // Port 0: enabled, ER; port 1: enabled, LR, module absent.
        areset_clk156       = 1'b1;
        xphy_config         = {3'b011, 3'b001};
        sfp_module_detect_n = 2'b10;
        sfp_signal_lost     = 2'b10;
        sfp_tx_fault        = 2'b00;
        flap_clr            = 2'b00;
        qplllock            = 1'b1;
        core_status         = 16'h0001;

        repeat (3) @(negedge clk156);
        sb_push("rst_tx_disable", 2'b11);
        sb_push("rst_signal_detect", 2'b00);
        sb_push("rst_link_up", 2'b00);
        sb_push("rst_flap_cnt", 32'h0);
        // Synchronisers hold safe values: no module, fault asserted.
        sb_push("rst_xphy_status", {5'b01001, 5'b11001});
        sb_push("pmd_init", {3'b110, 3'b101});
        sb_pop(sfp_tx_disable);
        sb_pop(signal_detect);
        sb_pop(link_up);
        sb_pop(flap_cnt);
        sb_pop(xphy_status);
        sb_pop(pma_pmd_type);

        // Bring-up of port 0 from reset release.
        @(negedge clk156);
        areset_clk156 = 1'b0;
        sb_push("bringup_tx_disable_fall", 4);
        sb_push("bringup_signal_detect_rise", DB + 2);
        sb_push("bringup_link_up_rise", DB + 5);
        measure_bringup(0, 3*DB + 10, t_txd, t_sd, t_link);
        sb_pop(t_txd);
        sb_pop(t_sd);
        sb_pop(t_link);
        sb_push("up_xphy_status", {5'b00001, 5'b10111});
        sb_push("port1_idle_tx_disable", 1'b1);
        sb_push("port1_idle_link_up", 1'b0);
        sb_pop(xphy_status);
        sb_pop(sfp_tx_disable[1]);
        sb_pop(link_up[1]);

        // One-cycle loss-of-signal glitch on port 0 while UP.
        @(negedge clk156);
        sfp_signal_lost[0] = 1'b1;
        @(negedge clk156);
        sfp_signal_lost[0] = 1'b0;
        sb_push("glitch_sd_fall", 2);
        sb_push("glitch_link_fall", 4);
        sb_push("glitch_link_back", DB + 5);
        t_fall_sd = -1; t_fall_link = -1; t_back = -1;
        for (int i = 1; i <= 3*DB + 10; i++) begin
            @(posedge clk156); #1;
            if (t_fall_sd < 0 && !signal_detect[0]) t_fall_sd = i;
            if (t_fall_link < 0 && !link_up[0]) t_fall_link = i;
            else if (t_fall_link >= 0 && t_back < 0 && link_up[0]) t_back = i;
        end
        sb_pop(t_fall_sd);
        sb_pop(t_fall_link);
        sb_pop(t_back);
        sb_push("glitch_flap_cnt", flap_exp(1));
        sb_pop(flap_cnt[15:0]);

        // tx_fault held 40 cycles: three full hold periods, then retry.
        @(negedge clk156);
        sfp_tx_fault[0] = 1'b1;
        hi_cnt = 0; first_hi = -1; t_back = -1; fault_bit = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk156); #1;
            if (sfp_tx_disable[0]) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
            if (i == 10) fault_bit = xphy_status[3];
            if (first_hi >= 0 && t_back < 0 && link_up[0]) t_back = i;
            if (i == 39) begin
                @(negedge clk156);
                sfp_tx_fault[0] = 1'b0;
            end
        end
        sb_push("fault_tx_disable_first", 3);
        sb_push("fault_tx_disable_cycles", 3*FH);
        sb_push("fault_status_bit", 1'b1);
        sb_push("fault_link_back", 3*FH + 5);
        sb_push("fault_flap_cnt", flap_exp(2));
        sb_pop(first_hi);
        sb_pop(hi_cnt);
        sb_pop(fault_bit);
        sb_pop(t_back);
        sb_pop(flap_cnt[15:0]);

        // PMD decode for all select codes.
        for (int s = 0; s < 4; s++) begin
            @(negedge clk156);
            xphy_config[2:1] = 2'(s);
            #1;
            sb_push($sformatf("pmd_sel%0d", s), (s >= 2) ? 3'b111 : ((s == 1) ? 3'b110 : 3'b101));
            sb_pop(pma_pmd_type[2:0]);
        end
        @(negedge clk156);
        xphy_config[2:1] = 2'b00;

        // Disable while UP: OFF next edge, tx_disable registered one edge later.
        @(negedge clk156);
        xphy_config[0] = 1'b0;
        repeat (2) @(posedge clk156);
        #1;
        sb_push("disable_tx_disable", 1'b1);
        sb_push("disable_link_up", 1'b0);
        sb_push("disable_signal_detect_kept", 1'b1);
        sb_push("disable_flap_cnt", flap_exp(3));
        sb_pop(sfp_tx_disable[0]);
        sb_pop(link_up[0]);
        sb_pop(signal_detect[0]);
        sb_pop(flap_cnt[15:0]);

        // flap_clr alone clears.
        @(negedge clk156);
        flap_clr[0] = 1'b1;
        @(negedge clk156);
        flap_clr[0] = 1'b0;
        sb_push("flap_clr_alone", 16'd0);
        sb_pop(flap_cnt[15:0]);

        // Re-enable: signal already debounced, so UP after OFF->NO_MODULE->WAIT_SIG->WAIT_LOCK.
        @(negedge clk156);
        xphy_config[0] = 1'b1;
        sb_push("reenable_link_up", 5);
        wait_link(0, 40, t_link);
        sb_pop(t_link);

        // flap_clr in the same cycle as an exit from UP.
        @(negedge clk156);
        xphy_config[0] = 1'b0;
        flap_clr[0]    = 1'b1;
        @(negedge clk156);
        flap_clr[0]    = 1'b0;
        sb_push("flap_clr_with_exit", flap_exp(1));
        sb_pop(flap_cnt[15:0]);

        // Port 1 comes up independently while port 0 stays disabled.
        @(negedge clk156);
        sfp_module_detect_n[1] = 1'b0;
        sfp_signal_lost[1]     = 1'b0;
        core_status[8]         = 1'b1;
        sb_push("port1_link_up", DB + 5);
        wait_link(1, 3*DB + 10, t_link);
        sb_pop(t_link);
        sb_push("port0_still_disabled", 1'b1);
        sb_pop(sfp_tx_disable[0]);

        // Asynchronous reset mid-operation: outputs return to safe state without a clock.
        @(negedge clk156);
        areset_clk156  = 1'b1;
        xphy_config[0] = 1'b1;
        #1;
        sb_push("midrst_tx_disable", 2'b11);
        sb_push("midrst_link_up", 2'b00);
        sb_push("midrst_signal_detect", 2'b00);
        sb_push("midrst_flap_cnt", 32'h0);
        sb_pop(sfp_tx_disable);
        sb_pop(link_up);
        sb_pop(signal_detect);
        sb_pop(flap_cnt);

        @(negedge clk156);
        areset_clk156 = 1'b0;
        sb_push("rebringup_tx_disable_fall", 4);
        sb_push("rebringup_signal_detect_rise", DB + 2);
        sb_push("rebringup_link_up_rise", DB + 5);
        measure_bringup(1, 3*DB + 10, t_txd, t_sd, t_link);
        sb_pop(t_txd);
        sb_pop(t_sd);
        sb_pop(t_link);

        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
